// File: rtl/regfile_wr_arb.sv
// ---------------------------------------------------------------------------
// RegfileWrArb: merges pipeline writebacks and load returns onto a single
// regfile write port. Writebacks always win. Load returns that lose
// arbitration wait in a 2-entry in-order buffer. A writeback to the same
// register makes any older buffered or incoming load to that register stale,
// so those loads are dropped. If the buffer head waits too long, a stall
// request asks upstream to pause writebacks until the buffer drains.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   wb_we, wb_tgt, wb_data      writeback request (never back-pressured)
//   ld_valid, ld_tgt, ld_data   load-return request
//   ld_ready                    load-return accept (buffer not full)
//   q_1, q_2                    decode source-register queries
//   q_pend_1, q_pend_2          queried register has a buffered load pending
//   we, target, write_data      registered regfile write port
//   stall_req                   registered request to hold writebacks
// ---------------------------------------------------------------------------
module regfile_wr_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [2:0]  wb_tgt,
    input  logic [15:0] wb_data,
    input  logic        ld_valid,
    input  logic [2:0]  ld_tgt,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    input  logic [2:0]  q_1,
    input  logic [2:0]  q_2,
    output logic        q_pend_1,
    output logic        q_pend_2,
    output logic        we,
    output logic [2:0]  target,
    output logic [15:0] write_data,
    output logic        stall_req
);

    typedef struct packed {
        logic        valid;
        logic [2:0]  tgt;
        logic [15:0] data;
    } entry_t;

    entry_t      fifo_q [2];
    entry_t      fifo_d [2];
    logic [1:0]  count_q, count_d;
    logic [1:0]  headAge_q, headAge_d;
    logic        stall_q, stall_d;
    logic        we_q, we_d;
    logic [2:0]  target_q, target_d;
    logic [15:0] wdata_q, wdata_d;

    logic   ldAccept, wbGrant, ldKill, ldLive;
    logic   kill0, kill1, headPop, bypass, push;
    logic   keep0, keep1;
    entry_t pushEntry;

    // Handshake and query outputs. ld_ready is forced low during reset so no
    // load can be accepted in a cycle whose edge will flush the buffer.
    always_comb begin
        ld_ready = rst_n && (count_q < 2'd2);
        q_pend_1 = (q_1 != 3'd0) &&
                   ((fifo_q[0].valid && fifo_q[0].tgt == q_1) ||
                    (fifo_q[1].valid && fifo_q[1].tgt == q_1));
        q_pend_2 = (q_2 != 3'd0) &&
                   ((fifo_q[0].valid && fifo_q[0].tgt == q_2) ||
                    (fifo_q[1].valid && fifo_q[1].tgt == q_2));
    end

    // Arbitration: writeback, then buffer head, then a same-cycle load as a
    // bypass. A granted writeback kills older loads to its register; r0
    // writes are never granted and never kill anything.
    always_comb begin
        ldAccept  = ld_valid && ld_ready;
        wbGrant   = wb_we && (wb_tgt != 3'd0);
        kill0     = wbGrant && fifo_q[0].valid && (fifo_q[0].tgt == wb_tgt);
        kill1     = wbGrant && fifo_q[1].valid && (fifo_q[1].tgt == wb_tgt);
        ldKill    = wbGrant && (ld_tgt == wb_tgt);
        ldLive    = ldAccept && (ld_tgt != 3'd0) && !ldKill;
        headPop   = !wbGrant && fifo_q[0].valid;
        bypass    = !wbGrant && !fifo_q[0].valid && ldLive;
        push      = ldLive && !bypass;
        keep0     = fifo_q[0].valid && !headPop && !kill0;
        keep1     = fifo_q[1].valid && !kill1;
        pushEntry = '{valid: 1'b1, tgt: ld_tgt, data: ld_data};
    end

    // Next buffer contents: survivors stay in order at the front and a push
    // lands behind them. Both survivors only happen when full, and a full
    // buffer accepts nothing, so a push never overflows.
    always_comb begin
        fifo_d[0] = '0;
        fifo_d[1] = '0;
        if (keep0 && keep1) begin
            fifo_d[0] = fifo_q[0];
            fifo_d[1] = fifo_q[1];
        end else if (keep0 || keep1) begin
            fifo_d[0] = keep0 ? fifo_q[0] : fifo_q[1];
            if (push) fifo_d[1] = pushEntry;
        end else if (push) begin
            fifo_d[0] = pushEntry;
        end
        count_d = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push};
    end

    // Head aging and stall request. The age restarts whenever the head
    // changes or the buffer is empty; the stall request latches at age 3 and
    // holds until the edge that empties the buffer.
    always_comb begin
        if (count_q == 2'd0 || headPop || kill0) begin
            headAge_d = 2'd0;
        end else if (headAge_q != 2'd3) begin
            headAge_d = headAge_q + 2'd1;
        end else begin
            headAge_d = headAge_q;
        end

        if (count_d == 2'd0) begin
            stall_d = 1'b0;
        end else if (headAge_d == 2'd3) begin
            stall_d = 1'b1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Write port mux; target/data hold their old value when nothing is granted.
    always_comb begin
        we_d     = 1'b0;
        target_d = target_q;
        wdata_d  = wdata_q;
        if (wbGrant) begin
            we_d     = 1'b1;
            target_d = wb_tgt;
            wdata_d  = wb_data;
        end else if (headPop) begin
            we_d     = 1'b1;
            target_d = fifo_q[0].tgt;
            wdata_d  = fifo_q[0].data;
        end else if (bypass) begin
            we_d     = 1'b1;
            target_d = ld_tgt;
            wdata_d  = ld_data;
        end
    end

    // State registers with synchronous reset that flushes buffered loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            count_q   <= 2'd0;
            headAge_q <= 2'd0;
            stall_q   <= 1'b0;
            we_q      <= 1'b0;
            target_q  <= 3'd0;
            wdata_q   <= 16'd0;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            count_q   <= count_d;
            headAge_q <= headAge_d;
            stall_q   <= stall_d;
            we_q      <= we_d;
            target_q  <= target_d;
            wdata_q   <= wdata_d;
        end
    end

    assign we         = we_q;
    assign target     = target_q;
    assign write_data = wdata_q;
    assign stall_req  = stall_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// ---------------------------------------------------------------------------
// Testbench for regfile_wr_arb. Expected regfile writes are queued as each
// stimulus cycle is driven; a monitor pops and compares on every DUT write.
// Directed checks cover handshake, stall, pending queries and reset.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [2:0]  wb_tgt;
    logic [15:0] wb_data;
    logic        ld_valid;
    logic [2:0]  ld_tgt;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [2:0]  q_1, q_2;
    logic        q_pend_1, q_pend_2;
    logic        we;
    logic [2:0]  target;
    logic [15:0] write_data;
    logic        stall_req;

    int          errors = 0;
    int          checks = 0;
    logic [18:0] expQ [$];
    logic [18:0] accQ [$];
    logic [18:0] monEntry;
    int          k;

    regfile_wr_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_we      (wb_we),
        .wb_tgt     (wb_tgt),
        .wb_data    (wb_data),
        .ld_valid   (ld_valid),
        .ld_tgt     (ld_tgt),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .q_1        (q_1),
        .q_2        (q_2),
        .q_pend_1   (q_pend_1),
        .q_pend_2   (q_pend_2),
        .we         (we),
        .target     (target),
        .write_data (write_data),
        .stall_req  (stall_req)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's worth of inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic wbWe, input logic [2:0] wbTgt,
                                 input logic [15:0] wbData, input logic ldValid,
                                 input logic [2:0] ldTgt, input logic [15:0] ldData);
        wb_we    = wbWe;
        wb_tgt   = wbTgt;
        wb_data  = wbData;
        ld_valid = ldValid;
        ld_tgt   = ldTgt;
        ld_data  = ldData;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every regfile write must match the oldest expected one.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'(we), 32'd0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("writeOrder", {13'd0, target, write_data}, {13'd0, monEntry});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        q_1   = 3'd0;
        q_2   = 3'd0;
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick(); tick(); tick();

        // Reset state.
        checkOutput("rstWe",     32'(we),         32'd0);
        checkOutput("rstTarget", 32'(target),     32'd0);
        checkOutput("rstData",   32'(write_data), 32'd0);
        checkOutput("rstStall",  32'(stall_req),  32'd0);
        checkOutput("rstReady",  32'(ld_ready),   32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("releaseReady", 32'(ld_ready), 32'd1);

        // Bypass: empty buffer, lone load goes straight to the regfile.
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
        expQ.push_back({3'd3, 16'h1234});
        tick();
        checkOutput("bypassWe",     32'(we),         32'd1);
        checkOutput("bypassTarget", 32'(target),     32'd3);
        checkOutput("bypassData",   32'(write_data), 32'h1234);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        q_1 = 3'd3;
        #1;
        checkOutput("bypassNoPend", 32'(q_pend_1), 32'd0);
        tick();
        checkOutput("idleWe",         32'(we),     32'd0);
        checkOutput("idleHoldTarget", 32'(target), 32'd3);

        // Collision: writeback wins, load follows one cycle later.
        applyStimulus(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
        expQ.push_back({3'd2, 16'hAAAA});
        expQ.push_back({3'd5, 16'h5555});
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        q_1 = 3'd5;
        q_2 = 3'd2;
        #1;
        checkOutput("collPend5",   32'(q_pend_1), 32'd1);
        checkOutput("collNoPend2", 32'(q_pend_2), 32'd0);
        checkOutput("collTarget1", 32'(target),   32'd2);
        tick();
        checkOutput("collTarget2", 32'(target),     32'd5);
        checkOutput("collData2",   32'(write_data), 32'h5555);
        checkOutput("collDrained", 32'(q_pend_1),   32'd0);
        tick();
        checkOutput("collIdle", 32'(we), 32'd0);

        // Kill: buffered r4 and same-cycle r4 load both die to a wb r4.
        applyStimulus(1'b1, 3'd1, 16'h1111, 1'b1, 3'd4, 16'h4444);
        expQ.push_back({3'd1, 16'h1111});
        tick();
        q_1 = 3'd4;
        applyStimulus(1'b1, 3'd4, 16'h4AAA, 1'b1, 3'd4, 16'h4BBB);
        checkOutput("killPendBefore", 32'(q_pend_1), 32'd1);
        checkOutput("killReady",      32'(ld_ready), 32'd1);
        expQ.push_back({3'd4, 16'h4AAA});
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput("killPendAfter", 32'(q_pend_1), 32'd0);
        tick();
        checkOutput("killNoWrite", 32'(we), 32'd0);

        // r0 load is handshaken and discarded; r0 writeback is ignored.
        applyStimulus(1'b1, 3'd0, 16'hDEAD, 1'b1, 3'd0, 16'hBEEF);
        checkOutput("r0Ready", 32'(ld_ready), 32'd1);
        tick();
        checkOutput("r0NoWrite1", 32'(we), 32'd0);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        checkOutput("r0NoWrite2", 32'(we), 32'd0);

        // Full/aging: six writeback cycles, three loads offered.
        k = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 3'd1, 16'(16'h0100 + c), 1'b1, 3'(5 + k), 16'(16'h5000 + k));
            checkOutput("agingReady", 32'(ld_ready), 32'(c < 2));
            expQ.push_back({3'd1, 16'(16'h0100 + c)});
            if (ld_ready) begin
                accQ.push_back({3'(5 + k), 16'(16'h5000 + k)});
                k++;
            end
            tick();
            checkOutput("agingStall", 32'(stall_req), 32'(c >= 3));
        end
        checkOutput("agingAccepted", 32'(k), 32'd2);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        q_1 = 3'd5;
        q_2 = 3'd6;
        #1;
        checkOutput("agingPend5", 32'(q_pend_1), 32'd1);
        checkOutput("agingPend6", 32'(q_pend_2), 32'd1);
        while (accQ.size() > 0) expQ.push_back(accQ.pop_front());
        tick();
        checkOutput("drainTarget1", 32'(target),    32'd5);
        checkOutput("drainStall1",  32'(stall_req), 32'd1);
        tick();
        checkOutput("drainTarget2", 32'(target),    32'd6);
        checkOutput("drainStall2",  32'(stall_req), 32'd0);
        tick();
        checkOutput("drainIdle", 32'(we), 32'd0);

        // Reset mid-operation with a full buffer drops everything.
        applyStimulus(1'b1, 3'd1, 16'h7001, 1'b1, 3'd5, 16'h7005);
        expQ.push_back({3'd1, 16'h7001});
        tick();
        applyStimulus(1'b1, 3'd1, 16'h7002, 1'b1, 3'd6, 16'h7006);
        expQ.push_back({3'd1, 16'h7002});
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput("fullReady", 32'(ld_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        checkOutput("midRstWe",    32'(we),        32'd0);
        checkOutput("midRstStall", 32'(stall_req), 32'd0);
        checkOutput("midRstReady", 32'(ld_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("midRelReady", 32'(ld_ready), 32'd1);
        checkOutput("midRelPend5", 32'(q_pend_1), 32'd0);
        checkOutput("midRelPend6", 32'(q_pend_2), 32'd0);
        tick();
        checkOutput("midRelNoWrite1", 32'(we), 32'd0);
        tick();
        checkOutput("midRelNoWrite2", 32'(we), 32'd0);

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 The block SHALL use one clock and a synchronous active-low reset, with the ports listed below (clock and reset first).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 wb_we  in  1  pipeline writeback request; never back-pressured.
REQ-005 wb_tgt  in  3  writeback target register.
REQ-006 wb_data  in  16  writeback value.
REQ-007 ld_valid  in  1  load-return request valid.
REQ-008 ld_tgt  in  3  load-return target register.
REQ-009 ld_data  in  16  load-return value.
REQ-010 ld_ready  out  1  load-return accept; a transfer completes when ld_valid=1 and ld_ready=1 in the same cycle.
REQ-011 q_1, q_2  in  3 each  decode source-register queries.
REQ-012 q_pend_1, q_pend_2  out  1 each  queried register has a buffered load write pending.
REQ-013 we  out  1  regfile write enable (registered).
REQ-014 target  out  3  regfile write target (registered).
REQ-015 write_data  out  16  regfile write value (registered).
REQ-016 stall_req  out  1  request for the pipeline to hold writebacks so the buffer can drain (registered).

Function
REQ-017 The block SHALL hold a 2-entry FIFO of accepted but ungranted load writes; each entry holds valid, tgt[2:0], data[15:0], and the FIFO has a count of 0..2.
REQ-018 ld_ready SHALL be 1 exactly when the registered count < 2.
REQ-019 Grant priority each cycle SHALL be: (1) wb, if wb_we=1 and wb_tgt!=0; else (2) the FIFO head; else (3) a load being accepted this cycle (bypass).
REQ-020 The granted write SHALL appear on we/target/write_data on the next rising edge (latency 1); with no grant, we=0 and target/write_data hold their previous values.
REQ-021 An accepted load that is not granted SHALL be pushed at the FIFO tail in the same edge.
REQ-022 A FIFO pop and push in the same cycle SHALL leave the count unchanged, and the pushed entry SHALL land behind any remaining entry.
REQ-023 A wb write with wb_tgt=0 SHALL be ignored: no grant, no kill.
REQ-024 An accepted load with ld_tgt=0 SHALL be handshaken and discarded: not pushed, not granted.
REQ-025 wb is always younger than any load: when wb is granted with target T, every valid FIFO entry with tgt=T, and any load accepted that same cycle with ld_tgt=T, SHALL be discarded.
REQ-026 Discarded entries SHALL be removed with the FIFO compacted in order, and the count SHALL drop accordingly in the same edge.
REQ-027 An age counter (2 bits) SHALL count consecutive cycles in which the FIFO is non-empty and the head is not granted; it SHALL reset to 0 on a head pop, a head kill, or FIFO empty.
REQ-028 stall_req SHALL be set on the edge where the age counter reaches 3, and SHALL clear on the edge where the FIFO becomes empty.
REQ-029 Upstream response to stall_req is advisory: wb keeps its priority even while stall_req=1.
REQ-030 q_pend_n SHALL be combinational, equal to 1 when q_n!=0 and any valid FIFO entry has tgt=q_n; a same-cycle incoming load SHALL NOT count toward q_pend_n.

Reset
REQ-031 While rst_n=0 at an edge, the block SHALL clear the FIFO and age counter and SHALL set we=0, target=0, write_data=0, stall_req=0.
REQ-032 ld_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-033 Reset asserted mid-operation SHALL drop all buffered writes with no regfile write issued.

Verification
REQ-034 Bypass: FIFO empty, wb_we=0, ld (tgt=3, data=0x1234) accepted -> next cycle we=1, target=3, write_data=0x1234; count stays 0.
REQ-035 Collision: wb (tgt=2, 0xAAAA) and ld (tgt=5, 0x5555) in cycle N, then idle -> cycle N+1 writes r2=0xAAAA; cycle N+2 writes r5=0x5555; q_pend_1 with q_1=5 reads 1 during cycle N+1.
REQ-036 Kill: FIFO holds tgt=4; wb tgt=4 arrives -> only the wb write is issued; the entry is removed and count=0; a same-cycle ld tgt=4 is handshaken and never written.
REQ-037 Full/aging: hold wb_we=1 (tgt=1) for 6 cycles while 3 loads are offered -> ld_ready=0 after two are buffered; stall_req=1 on the third cycle of head wait; once wb_we drops, both entries drain in FIFO order and stall_req clears on the empty edge.
REQ-038 r0 and reset: wb tgt=0 with a buffered tgt=0 entry impossible (ld tgt=0 accepted, not pushed, we stays 0); assert rst_n=0 with count=2 -> next edge count=0, we=0, stall_req=0.
